// File: rtl/adapter_btn_echo_master_spi.sv
// Test-fixture adapter: timed button pulse, sonar echo emulator and a mode-0 SPI master
// with optional expected-response checking (enabled by defining ADAPTER_EXPECT_CHECK_EN).
module adapter_btn_echo_master_spi #(
  parameter int SPI_DIV    = 4,
  parameter int ECHO_DELAY = 50,
  parameter int EXP_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic [31:0] btn_len,
  output logic        btn,
  input  logic        trig,
  input  logic [31:0] echo_width,
  output logic        echo,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [3:0]  tx_id,
  input  logic [27:0] tx_data,
  input  logic        exp_valid,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_cs,
  input  logic        spi_miso,
  output logic        rx_valid,
  output logic [31:0] rx_word,
  output logic        err,
  output logic        exp_ovf,
  output logic [1:0]  dbg_echo_state,
  output logic [1:0]  dbg_spi_state
);

  // tx handshake: a word transfers on a cycle where tx_valid && tx_ready; tx_ready is high
  // only while the SPI engine is idle and the caller holds tx_valid until it is accepted.

  typedef enum logic [1:0] {E_IDLE, E_DELAY, E_HIGH} echo_state_e;
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} spi_state_e;

  localparam logic [31:0] DELAY_INIT = (ECHO_DELAY > 0) ? 32'(ECHO_DELAY - 1) : 32'd0;
  localparam logic [31:0] DIV_LAST   = 32'(SPI_DIV - 1);
  localparam logic [31:0] GAP_LAST   = 32'(2 * SPI_DIV - 2);

  // ---------------- button pulse ----------------
  logic        btn_q;
  logic [31:0] btn_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q     <= 1'b0;
      btn_cnt_q <= '0;
    end else if (btn_start) begin
      btn_q     <= (btn_len != 32'd0);
      btn_cnt_q <= btn_len;
    end else if (btn_q) begin
      if (btn_cnt_q == 32'd1) begin
        btn_q     <= 1'b0;
        btn_cnt_q <= '0;
      end else begin
        btn_cnt_q <= btn_cnt_q - 32'd1;
      end
    end
  end

  assign btn = btn_q;

  // ---------------- echo emulator ----------------
  logic [2:0]  trig_sync_q;
  logic        trig_rise;
  echo_state_e echo_state_q;
  logic [31:0] echo_cnt_q;
  logic        echo_q;

  assign trig_rise = trig_sync_q[1] & ~trig_sync_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_sync_q  <= '0;
      echo_state_q <= E_IDLE;
      echo_cnt_q   <= '0;
      echo_q       <= 1'b0;
    end else begin
      trig_sync_q <= {trig_sync_q[1:0], trig};
      case (echo_state_q)
        E_IDLE: begin
          if (trig_rise) begin
            echo_state_q <= E_DELAY;
            echo_cnt_q   <= DELAY_INIT;
          end
        end
        E_DELAY: begin
          if (echo_cnt_q == 32'd0) begin
            if (echo_width != 32'd0) begin
              echo_state_q <= E_HIGH;
              echo_q       <= 1'b1;
              echo_cnt_q   <= echo_width - 32'd1;
            end else begin
              echo_state_q <= E_IDLE;
            end
          end else begin
            echo_cnt_q <= echo_cnt_q - 32'd1;
          end
        end
        E_HIGH: begin
          if (echo_cnt_q == 32'd0) begin
            echo_state_q <= E_IDLE;
            echo_q       <= 1'b0;
          end else begin
            echo_cnt_q <= echo_cnt_q - 32'd1;
          end
        end
        default: begin
          echo_state_q <= E_IDLE;
          echo_q       <= 1'b0;
        end
      endcase
    end
  end

  assign echo           = echo_q;
  assign dbg_echo_state = echo_state_q;

  // ---------------- SPI master ----------------
  spi_state_e  spi_state_q;
  logic        ready_q;
  logic        cs_q;
  logic        sclk_q;
  logic [31:0] tx_sh_q;
  logic [31:0] rx_sh_q;
  logic [31:0] div_cnt_q;
  logic [6:0]  half_q;
  logic        rx_valid_q;
  logic [31:0] rx_word_q;
  logic        frame_done;

  // First GAP cycle: the 32 received bits are complete and cs has just risen.
  assign frame_done = (spi_state_q == S_GAP) && (div_cnt_q == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_state_q <= S_IDLE;
      ready_q     <= 1'b0;
      cs_q        <= 1'b1;
      sclk_q      <= 1'b0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      div_cnt_q   <= '0;
      half_q      <= '0;
      rx_valid_q  <= 1'b0;
      rx_word_q   <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      case (spi_state_q)
        S_IDLE: begin
          if (tx_valid && ready_q) begin
            spi_state_q <= S_XFER;
            ready_q     <= 1'b0;
            cs_q        <= 1'b0;
            tx_sh_q     <= {tx_id, tx_data};
            div_cnt_q   <= '0;
            half_q      <= '0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_XFER: begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_q <= '0;
            half_q    <= half_q + 7'd1;
            if (half_q == 7'd64) begin
              cs_q        <= 1'b1;
              spi_state_q <= S_GAP;
            end else if (!half_q[0]) begin
              sclk_q  <= 1'b1;
              rx_sh_q <= {rx_sh_q[30:0], spi_miso};
            end else begin
              // Zero fill leaves MOSI low once the last bit has been shifted out.
              sclk_q  <= 1'b0;
              tx_sh_q <= {tx_sh_q[30:0], 1'b0};
            end
          end else begin
            div_cnt_q <= div_cnt_q + 32'd1;
          end
        end
        S_GAP: begin
          if (frame_done) begin
            rx_valid_q <= 1'b1;
            rx_word_q  <= rx_sh_q;
          end
          if (div_cnt_q == GAP_LAST) begin
            spi_state_q <= S_IDLE;
            ready_q     <= 1'b1;
            div_cnt_q   <= '0;
          end else begin
            div_cnt_q <= div_cnt_q + 32'd1;
          end
        end
        default: begin
          spi_state_q <= S_IDLE;
          cs_q        <= 1'b1;
          sclk_q      <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready      = ready_q;
  assign spi_cs        = cs_q;
  assign spi_clk       = sclk_q;
  assign spi_mosi      = tx_sh_q[31];
  assign rx_valid      = rx_valid_q;
  assign rx_word       = rx_word_q;
  assign dbg_spi_state = spi_state_q;

  // ---------------- expectation check ----------------
`ifdef ADAPTER_EXPECT_CHECK_EN
  localparam int AW = $clog2(EXP_DEPTH);

  logic [31:0] fifo_mem [EXP_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_pop;
  logic        fifo_push;
  logic        err_q;
  logic        ovf_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign fifo_pop   = frame_done && !fifo_empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign fifo_push  = exp_valid && (!fifo_full || fifo_pop);

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q[AW-1:0]] <= {tx_id, tx_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (exp_valid && !fifo_push) ovf_q <= 1'b1;
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        if (fifo_mem[rd_ptr_q[AW-1:0]] != rx_sh_q) err_q <= 1'b1;
      end
    end
  end

  assign err     = err_q;
  assign exp_ovf = ovf_q;
`else
  logic unused_exp_valid;
  assign unused_exp_valid = exp_valid;
  assign err              = 1'b0;
  assign exp_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_adapter_btn_echo_master_spi.sv
// Bench for adapter_btn_echo_master_spi: button/echo timing, SPI frames against a slave
// model with a scoreboard of expected received words, and expectation FIFO behaviour.
module tb_adapter_btn_echo_master_spi;

  localparam int SPI_DIV    = 4;
  localparam int ECHO_DELAY = 50;
  localparam int EXP_DEPTH  = 8;
`ifdef ADAPTER_EXPECT_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        btn_start;
  logic [31:0] btn_len;
  logic        btn;
  logic        trig;
  logic [31:0] echo_width;
  logic        echo;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  tx_id;
  logic [27:0] tx_data;
  logic        exp_valid;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_cs;
  logic        spi_miso;
  logic        rx_valid;
  logic [31:0] rx_word;
  logic        err;
  logic        exp_ovf;
  logic [1:0]  dbg_echo_state;
  logic [1:0]  dbg_spi_state;

  adapter_btn_echo_master_spi #(
    .SPI_DIV(SPI_DIV), .ECHO_DELAY(ECHO_DELAY), .EXP_DEPTH(EXP_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_len(btn_len), .btn(btn),
    .trig(trig), .echo_width(echo_width), .echo(echo),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_id(tx_id), .tx_data(tx_data),
    .exp_valid(exp_valid), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_miso(spi_miso), .rx_valid(rx_valid), .rx_word(rx_word), .err(err),
    .exp_ovf(exp_ovf), .dbg_echo_state(dbg_echo_state), .dbg_spi_state(dbg_spi_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard + SPI slave model ----------------
  logic [31:0] exp_q[$];
  logic [31:0] mosi_q[$];
  logic [31:0] slave_q[$];

  logic [31:0] sl_sh;
  logic [31:0] mosi_cap;
  int          nbits;
  int          rx_count;
  int          cs_fall_cyc, cs_rise_cyc, last_fall_cyc, last_gap;
  logic        have_rise, prev_cs, prev_sclk, rx_prev;

  initial begin
    logic [31:0] e;
    prev_cs = 1'b1; prev_sclk = 1'b0; rx_prev = 1'b0; have_rise = 1'b0;
    spi_miso = 1'b0; nbits = 0; rx_count = 0; sl_sh = '0; mosi_cap = '0;
    cs_fall_cyc = 0; cs_rise_cyc = 0; last_fall_cyc = 0; last_gap = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cs = 1'b1; prev_sclk = 1'b0; rx_prev = 1'b0; have_rise = 1'b0;
        spi_miso = 1'b0; nbits = 0;
      end else begin
        if (prev_cs && !spi_cs) begin
          sl_sh       = (slave_q.size() > 0) ? slave_q.pop_front() : 32'h0;
          spi_miso    = sl_sh[31];
          nbits       = 0;
          mosi_cap    = '0;
          cs_fall_cyc = cyc;
          if (have_rise) begin
            last_gap = cyc - cs_rise_cyc;
            check_eq("cs_gap_min", 32'(last_gap >= 2 * SPI_DIV), 32'd1);
          end
        end
        if (!spi_cs && !prev_sclk && spi_clk) begin
          nbits++;
          mosi_cap = {mosi_cap[30:0], spi_mosi};
          if (nbits == 1) check_eq("first_rise_delay", 32'(cyc - cs_fall_cyc), 32'(SPI_DIV));
        end
        if (!spi_cs && prev_sclk && !spi_clk) begin
          sl_sh         = {sl_sh[30:0], 1'b0};
          spi_miso      = sl_sh[31];
          last_fall_cyc = cyc;
        end
        if (!prev_cs && spi_cs) begin
          cs_rise_cyc = cyc;
          have_rise   = 1'b1;
          check_eq("cs_rise_delay", 32'(cyc - last_fall_cyc), 32'(SPI_DIV));
        end
        if (rx_valid) begin
          rx_count++;
          check_eq("rx_single_pulse", 32'(rx_prev), 32'd0);
          check_eq("rx_valid_delay", 32'(cyc - cs_rise_cyc), 32'd1);
          if (exp_q.size() == 0) begin
            check_eq("rx_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check_eq("rx_word", rx_word, e);
            e = mosi_q.pop_front();
            check_eq("mosi_word", mosi_cap, e);
            check_eq("bits_per_frame", 32'(nbits), 32'd32);
          end
        end
        rx_prev   = rx_valid;
        prev_cs   = spi_cs;
        prev_sclk = spi_clk;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_btn(input logic [31:0] len);
    btn_start = 1'b1;
    btn_len   = len;
    @(negedge clk);
    btn_start = 1'b0;
  endtask

  task automatic measure_high(input logic which_echo, output int cnt);
    cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      if (!(which_echo ? echo : btn)) break;
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic count_high(input logic which_echo, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (which_echo ? echo : btn) cnt++;
    end
  endtask

  task automatic send_frame(input logic [3:0] id, input logic [27:0] data, input logic [31:0] miso);
    logic acc;
    exp_q.push_back(miso);
    mosi_q.push_back({id, data});
    slave_q.push_back(miso);
    tx_id    = id;
    tx_data  = data;
    tx_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (tx_ready) acc = 1'b1;
      @(negedge clk);
      if (acc) break;
    end
    tx_valid = 1'b0;
    if (!acc) check_eq("tx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_exp(input logic [3:0] id, input logic [27:0] data);
    tx_id     = id;
    tx_data   = data;
    exp_valid = 1'b1;
    @(negedge clk);
    exp_valid = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    for (int i = 0; i < 3000; i++) begin
      if (rx_count >= target) break;
      @(negedge clk);
    end
    if (rx_count < target) check_eq("rx_timeout", 32'(rx_count), 32'(target));
  endtask

  function automatic logic [27:0] rnd28();
    return 28'($urandom_range(0, 32'h0fff_ffff));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int          cnt, lat, base;
    logic [27:0] d [9];
    logic [31:0] m;

    rst_n = 1'b0; btn_start = 1'b0; btn_len = '0; trig = 1'b0; echo_width = '0;
    tx_valid = 1'b0; tx_id = '0; tx_data = '0; exp_valid = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check_eq("rst_btn", 32'(btn), 32'd0);
    check_eq("rst_echo", 32'(echo), 32'd0);
    check_eq("rst_cs", 32'(spi_cs), 32'd1);
    check_eq("rst_sclk", 32'(spi_clk), 32'd0);
    check_eq("rst_mosi", 32'(spi_mosi), 32'd0);
    check_eq("rst_tx_ready", 32'(tx_ready), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_word", rx_word, 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_ovf", 32'(exp_ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("tx_ready_after_rst", 32'(tx_ready), 32'd1);

    // button
    pulse_btn(32'd1500);
    measure_high(1'b0, cnt);
    check_eq("btn_len_1500", 32'(cnt), 32'd1500);
    pulse_btn(32'd0);
    count_high(1'b0, 20, cnt);
    check_eq("btn_len_0", 32'(cnt), 32'd0);
    pulse_btn(32'd100);
    repeat (29) @(negedge clk);
    pulse_btn(32'd50);
    measure_high(1'b0, cnt);
    check_eq("btn_restart", 32'(cnt), 32'd50);

    // echo
    echo_width = 32'd500;
    trig = 1'b1;
    lat  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 10) trig = 1'b0;
      if (echo) break;
    end
    check_eq("echo_latency_range",
             32'(lat >= ECHO_DELAY + 2 && lat <= ECHO_DELAY + 3), 32'd1);
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!echo) break;
      cnt++;
      if (cnt == 100) trig = 1'b1;
      if (cnt == 110) trig = 1'b0;
      @(negedge clk);
    end
    check_eq("echo_width_500", 32'(cnt), 32'd500);
    count_high(1'b1, ECHO_DELAY + 20, cnt);
    check_eq("echo_retrig_ignored", 32'(cnt), 32'd0);
    echo_width = 32'd0;
    trig = 1'b1;
    repeat (5) @(negedge clk);
    trig = 1'b0;
    count_high(1'b1, ECHO_DELAY + 20, cnt);
    check_eq("echo_width_0", 32'(cnt), 32'd0);

    // single SPI frame
    send_frame(4'd14, 28'd1, 32'h0100_0000);
    check_eq("tx_ready_busy", 32'(tx_ready), 32'd0);
    wait_rx(1);
    repeat (20) @(negedge clk);
    check_eq("rx_word_hold", rx_word, 32'h0100_0000);
    check_eq("err_no_exp", 32'(err), 32'd0);

    // back-to-back frames: caller holds tx_valid while busy
    send_frame(4'($urandom_range(0, 15)), rnd28(), $urandom());
    send_frame(4'($urandom_range(0, 15)), rnd28(), $urandom());
    wait_rx(3);
    check_eq("cs_gap_exact", 32'(last_gap), 32'(2 * SPI_DIV));

    // six matching expectations
    for (int i = 0; i < 6; i++) begin
      d[i] = 28'h500000a - 28'(i) * 28'h1000000;
      push_exp(4'd1, d[i]);
    end
    base = rx_count;
    for (int i = 0; i < 6; i++) send_frame(4'($urandom_range(0, 15)), rnd28(), {4'd1, d[i]});
    wait_rx(base + 6);
    check_eq("err_matching", 32'(err), 32'd0);

    // reset in the middle of a frame
    base = rx_count;
    send_frame(4'hA, rnd28(), $urandom());
    for (int i = 0; i < 1000; i++) begin
      if (nbits >= 16) break;
      @(negedge clk);
    end
    check_eq("abort_reached_bit16", 32'(nbits >= 16), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_cs_high", 32'(spi_cs), 32'd1);
    check_eq("abort_sclk_low", 32'(spi_clk), 32'd0);
    void'(exp_q.pop_back());
    void'(mosi_q.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("abort_no_rx", 32'(rx_count), 32'(base));
    check_eq("abort_err", 32'(err), 32'd0);

    // corrupted frame 3
    for (int i = 0; i < 6; i++) push_exp(4'd1, d[i]);
    for (int i = 0; i < 6; i++) begin
      m = {4'd1, d[i]} ^ ((i == 2) ? 32'h0000_0010 : 32'h0);
      base = rx_count;
      send_frame(4'($urandom_range(0, 15)), rnd28(), m);
      wait_rx(base + 1);
      if (i == 1) check_eq("err_before_bad", 32'(err), 32'd0);
      if (i == 2) check_eq("err_after_bad", 32'(err), 32'(CHK_EN));
    end
    check_eq("err_sticky", 32'(err), 32'(CHK_EN));
    check_eq("ovf_none", 32'(exp_ovf), 32'd0);

    // overflow: nine pushes, first eight kept in order
    do_reset();
    check_eq("err_cleared", 32'(err), 32'd0);
    for (int i = 0; i < 9; i++) begin
      d[i] = 28'h0abc000 + 28'(i) * 28'h0010101;
      push_exp(4'(i), d[i]);
    end
    check_eq("ovf_set", 32'(exp_ovf), 32'(CHK_EN));
    base = rx_count;
    for (int i = 0; i < 8; i++) send_frame(4'($urandom_range(0, 15)), rnd28(), {4'(i), d[i]});
    wait_rx(base + 8);
    check_eq("err_fifo_order", 32'(err), 32'd0);
    send_frame(4'd3, rnd28(), 32'hDEAD_BEEF);
    wait_rx(base + 9);
    check_eq("err_empty_no_check", 32'(err), 32'd0);
    check_eq("ovf_sticky", 32'(exp_ovf), 32'(CHK_EN));
    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
